// File: rtl/debounce_pkg.sv
// Shared definitions for the debouncer block: FSM state encoding and
// the default stability window (20 ms at 12 MHz).
package debounce_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam int DEB_NCYC_DEFAULT = 240000;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous board input.
// Synchronous active-high reset clears both stages to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  // Two back-to-back flops; only q is safe to use downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/debouncer.sv
// Button/switch debouncer: synchronises din, requires NCYC consecutive
// cycles of difference from dout before dout follows, and emits
// registered single-cycle rise/fall pulses.
// Optional macro DEBOUNCE_TOGGLE_EN adds a push-on/push-off 'toggle'
// output that inverts on the edge after each rise pulse.
module debouncer
  import debounce_pkg::*;
#(
  parameter int NCYC = DEB_NCYC_DEFAULT,
  parameter int CW   = $clog2(NCYC)
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
`ifdef DEBOUNCE_TOGGLE_EN
  ,
  output logic toggle
`endif
);

  // Terminal count: the NCYC-th consecutive differing sample.
  localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

  logic          s2;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          dout_d, rise_d, fall_d;

  // Stage 0: bring the raw input into the clock domain.
  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (s2)
  );

  // Stage 1: state, counter and registered outputs; reset wins over all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt     <= '0;
      dout    <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt     <= cnt_d;
      dout    <= dout_d;
      rise    <= rise_d;
      fall    <= fall_d;
    end
  end

  // Next-state logic: count while s2 disagrees with dout, abort on bounce.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt;
    dout_d  = dout;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (s2 != dout) begin
          state_d = ST_WAIT;
          cnt_d   = CW'(1);
        end
      end
      ST_WAIT: begin
        if (s2 == dout) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          dout_d  = s2;
          rise_d  = s2;
          fall_d  = ~s2;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef DEBOUNCE_TOGGLE_EN
  // Stage 2: push-on/push-off level, flips the edge after each rise pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      toggle <= 1'b0;
    end else if (rise) begin
      toggle <= ~toggle;
    end
  end
`endif

endmodule

// File: tb/tb_debouncer.sv
// Scoreboard bench for debouncer with NCYC = 4. The driver applies one
// input vector per clock and queues the hand-derived outputs expected
// after that edge; a monitor pops and compares on the falling edge.
module tb_debouncer;

  localparam int NCYC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic dout, rise, fall;
`ifdef DEBOUNCE_TOGGLE_EN
  logic toggle;
`endif

  typedef struct packed {
    logic d;
    logic r;
    logic f;
    logic t;
  } exp_t;

  exp_t  sb[$];
  exp_t  got_e;
  string phase = "reset";
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  debouncer #(.NCYC(NCYC)) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (dout),
    .rise (rise),
    .fall (fall)
`ifdef DEBOUNCE_TOGGLE_EN
    ,
    .toggle (toggle)
`endif
  );

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %b expected %b at %0t", phase, name, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per clock, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        got_e = sb.pop_front();
        chk("dout", dout, got_e.d);
        chk("rise", rise, got_e.r);
        chk("fall", fall, got_e.f);
`ifdef DEBOUNCE_TOGGLE_EN
        chk("toggle", toggle, got_e.t);
`endif
      end
    end
  end

  // Apply one vector, wait for its edge, queue the expected outputs.
  task automatic step(input logic r, input logic d,
                      input logic ed, input logic er, input logic ef, input logic et);
    exp_t e;
    rst = r;
    din = d;
    @(posedge clk);
    #1;
    e.d = ed;
    e.r = er;
    e.f = ef;
    e.t = et;
    sb.push_back(e);
  endtask

  // A clean held level change over 8 edges: old level through edge 5,
  // new level with its pulse on edge 6, toggle updates on edge 7 after a rise.
  task automatic transition(input logic newd, input logic tin);
    logic tout;
    tout = tin ^ newd;
    for (int i = 1; i <= 8; i++) begin
      if (i <= 5)      step(1'b0, newd, ~newd, 1'b0, 1'b0, tin);
      else if (i == 6) step(1'b0, newd, newd, newd, ~newd, tin);
      else             step(1'b0, newd, newd, 1'b0, 1'b0, tout);
    end
  endtask

  initial begin
    // Reset held 3 cycles with din high.
    phase = "reset";
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    phase = "press";
    transition(1'b1, 1'b0);

    phase = "release";
    transition(1'b0, 1'b1);

    // Bounce 1,0,1,0,1 then hold 0: dout stays 0, no pulses.
    phase = "bounce";
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Press for 4 cycles (in WAIT), then reset for 1 cycle.
    phase = "midwait";
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full latency restarts from the first post-reset edge.
    phase = "post_reset_press";
    transition(1'b1, 1'b0);

    phase = "release2";
    transition(1'b0, 1'b1);

    phase = "press2";
    transition(1'b1, 1'b1);

    // Drain the scoreboard within a bounded number of cycles.
    phase = "drain";
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain/queue: got %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
